// File: rtl/mer_window_meas_pkg.sv
// Shared definitions for the MER window measurement block:
// FSM state codes, default widths and the quotient format.
package mer_window_meas_pkg;

   localparam int MER_ERR_W    = 18;
   localparam int MER_LOG2_WIN = 10;
   localparam int MER_Q_FRAC   = 8;
   localparam int MER_QW       = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mer_state_e;

endpackage

// File: rtl/mer_window_meas_div.sv
// 16-iteration restoring divider, one quotient bit per clock,
// MSB first, with saturation detect latched at start.
module ufrac_div16
   import mer_window_meas_pkg::*;
#(
   parameter int NW = 2*MER_ERR_W + MER_Q_FRAC,
   parameter int DW = 2*MER_ERR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [NW-1:0]     num_i,
   input  logic [DW-1:0]     den_i,
   output logic              done_o,
   output logic              sat_o,
   output logic [MER_QW-1:0] quo_o
);

   localparam int CW = (NW > DW + MER_QW) ? NW : DW + MER_QW;
   localparam int IW = $clog2(MER_QW);
   localparam logic [IW-1:0] LAST = IW'(MER_QW - 1);

   logic [CW-1:0]     rem_q;
   logic [CW-1:0]     dsh_q;
   logic [MER_QW-1:0] quo_q;
   logic [IW-1:0]     it_q;
   logic              run_q;
   logic              sat_q;
   logic [CW-1:0]     num_x;
   logic [CW-1:0]     den_x16;
   logic              sat_now;
   logic              ge;

   assign num_x   = CW'(num_i);
   assign den_x16 = CW'(den_i) << MER_QW;
   assign sat_now = (den_i == '0) || (num_x >= den_x16);
   assign ge      = (rem_q >= dsh_q);

   // Load operands on start, then subtract-and-shift once per clock
   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q <= '0;
         dsh_q <= '0;
         quo_q <= '0;
         it_q  <= '0;
         run_q <= 1'b0;
         sat_q <= 1'b0;
      end else if (start_i) begin
         rem_q <= num_x;
         dsh_q <= CW'(den_i) << (MER_QW - 1);
         quo_q <= '0;
         it_q  <= '0;
         run_q <= 1'b1;
         sat_q <= sat_now;
      end else if (run_q) begin
         rem_q <= ge ? rem_q - dsh_q : rem_q;
         dsh_q <= dsh_q >> 1;
         quo_q <= {quo_q[MER_QW-2:0], ge};
         it_q  <= it_q + 1'b1;
         if (it_q == LAST) run_q <= 1'b0;
      end
   end

   assign done_o = run_q && (it_q == LAST);
   assign sat_o  = sat_q;
   assign quo_o  = quo_q;

endmodule

// File: rtl/mer_window_meas.sv
// Windowed slicer-error statistics: MSE, DC error and the
// signal-to-MSE ratio in UQ8.8, one result set per window.
module mer_window_meas
   import mer_window_meas_pkg::*;
#(
   parameter int ERR_W    = MER_ERR_W,
   parameter int LOG2_WIN = MER_LOG2_WIN,
   parameter int Q_FRAC   = MER_Q_FRAC
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic signed [ERR_W-1:0] err,
   input  logic [2*ERR_W-1:0]      sig_pwr,
   output logic [2*ERR_W-1:0]      mse_out,
   output logic signed [ERR_W-1:0] dc_out,
   output logic [MER_QW-1:0]       mer_ratio,
   output logic                    res_valid,
   output logic                    busy,
   output logic                    overrun
);

   localparam int PW  = 2*ERR_W;
   localparam int SQW = 2*ERR_W + LOG2_WIN;
   localparam int DCW = ERR_W + LOG2_WIN;
   localparam int NW  = 2*ERR_W + Q_FRAC;

   mer_state_e state_q, state_d;

   logic [LOG2_WIN-1:0]     sym_cnt_q;
   logic [SQW-1:0]          acc_sq_q;
   logic signed [DCW-1:0]   acc_dc_q;
   logic [PW-1:0]           snap_mse_q;
   logic signed [ERR_W-1:0] snap_dc_q;
   logic [PW-1:0]           snap_pwr_q;

   logic signed [PW-1:0]    sq_s;
   logic [SQW-1:0]          sum_sq;
   logic signed [DCW-1:0]   sum_dc;
   logic                    win_end;
   logic [NW-1:0]           num_w;
   logic                    div_start;
   logic                    div_done;
   logic                    div_sat;
   logic [MER_QW-1:0]       div_quo;

   assign sq_s    = PW'(err) * PW'(err);
   assign sum_sq  = acc_sq_q + SQW'($unsigned(sq_s));
   assign sum_dc  = acc_dc_q + DCW'(err);
   assign win_end = clk_en && (sym_cnt_q == '1);
   assign num_w   = NW'(snap_pwr_q) << Q_FRAC;

   // Symbol counter and accumulators; window end restarts both sums
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_cnt_q <= '0;
         acc_sq_q  <= '0;
         acc_dc_q  <= '0;
      end else if (clk_en) begin
         sym_cnt_q <= sym_cnt_q + 1'b1;
         if (win_end) begin
            acc_sq_q <= '0;
            acc_dc_q <= '0;
         end else begin
            acc_sq_q <= sum_sq;
            acc_dc_q <= sum_dc;
         end
      end
   end

   // Capture the scaled window totals only when the pipeline is free
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_mse_q <= '0;
         snap_dc_q  <= '0;
         snap_pwr_q <= '0;
      end else if (win_end && state_q == ST_IDLE) begin
         snap_mse_q <= PW'(sum_sq >> LOG2_WIN);
         snap_dc_q  <= ERR_W'(sum_dc >>> LOG2_WIN);
         snap_pwr_q <= sig_pwr;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and divider launch
   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      unique case (state_q)
         ST_IDLE: if (win_end) state_d = ST_PREP;
         ST_PREP: begin
            div_start = 1'b1;
            state_d   = ST_DIV;
         end
         ST_DIV:  if (div_done) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   ufrac_div16 #(
      .NW (NW),
      .DW (PW)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .start_i (div_start),
      .num_i   (num_w),
      .den_i   (snap_mse_q),
      .done_o  (div_done),
      .sat_o   (div_sat),
      .quo_o   (div_quo)
   );

   // Result registers, status flags and the sticky overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         mse_out   <= '0;
         dc_out    <= '0;
         mer_ratio <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (state_q == ST_PREP) busy <= 1'b1;
         if (state_q == ST_DONE) begin
            mse_out   <= snap_mse_q;
            dc_out    <= snap_dc_q;
            mer_ratio <= div_sat ? '1 : div_quo;
            res_valid <= 1'b1;
            busy      <= 1'b0;
         end
         if (win_end && state_q != ST_IDLE) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mer_window_meas.sv
// Directed bench for mer_window_meas with a window-level
// arithmetic model checked every clock.
module tb_mer_window_meas;

   localparam int EW  = 18;
   localparam int LW  = 2;
   localparam int WIN = 1 << LW;
   localparam int LAT = 18;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 clk_en;
   logic signed [EW-1:0] err;
   logic [2*EW-1:0]      sig_pwr;
   logic [2*EW-1:0]      mse_out;
   logic signed [EW-1:0] dc_out;
   logic [15:0]          mer_ratio;
   logic                 res_valid;
   logic                 busy;
   logic                 overrun;

   always #5 clk = ~clk;

   mer_window_meas #(
      .ERR_W    (EW),
      .LOG2_WIN (LW),
      .Q_FRAC   (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .err       (err),
      .sig_pwr   (sig_pwr),
      .mse_out   (mse_out),
      .dc_out    (dc_out),
      .mer_ratio (mer_ratio),
      .res_valid (res_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   int vecs = 0;
   int miss = 0;
   int npulse = 0;
   int p0;

   longint cyc = 0;
   int     nsym;
   longint ssq, sdc;
   bit     pend;
   longint pend_at, p_mse, p_dc, p_rat;
   longint e_mse, e_dc, e_rat;
   bit     e_val, e_busy, e_ovr;

   function automatic longint floor_div(input longint s, input longint d);
      longint q;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint ratio(input longint pwr, input longint mse);
      longint num;
      num = pwr * 256;
      if (mse == 0 || num >= mse * 65536) return 65535;
      return num / mse;
   endfunction

   task automatic chk(input string nm, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      cyc++;
      if (reset) begin
         nsym = 0; ssq = 0; sdc = 0; pend = 0;
         e_mse = 0; e_dc = 0; e_rat = 0;
         e_val = 0; e_busy = 0; e_ovr = 0;
         return;
      end
      e_val = 0;
      if (clk_en) begin
         nsym++;
         ssq += longint'(err) * longint'(err);
         sdc += longint'(err);
         if (nsym == WIN) begin
            if (pend) e_ovr = 1;
            else begin
               p_mse   = ssq / WIN;
               p_dc    = floor_div(sdc, WIN);
               p_rat   = ratio(longint'(sig_pwr), p_mse);
               pend    = 1;
               pend_at = cyc + LAT;
            end
            nsym = 0; ssq = 0; sdc = 0;
         end
      end
      if (pend && cyc == pend_at) begin
         e_mse = p_mse; e_dc = p_dc; e_rat = p_rat;
         e_val = 1; pend = 0;
      end
      e_busy = pend && (cyc >= pend_at - (LAT - 1));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (res_valid === 1'b1) npulse++;
      chk("mse_out",   mse_out,   e_mse);
      chk("dc_out",    dc_out,    e_dc);
      chk("mer_ratio", mer_ratio, e_rat);
      chk("res_valid", res_valid, e_val);
      chk("busy",      busy,      e_busy);
      chk("overrun",   overrun,   e_ovr);
   endtask

   task automatic send_sym(input int e, input longint p);
      clk_en  = 1'b1;
      err     = EW'(e);
      sig_pwr = 36'(p);
      step();
      clk_en  = 1'b0;
      repeat (31) step();
   endtask

   task automatic win(input int e0, input int e1, input int e2,
                      input int e3, input longint p);
      p0 = npulse;
      send_sym(e0, p);
      send_sym(e1, p);
      send_sym(e2, p);
      send_sym(e3, p);
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b0; err = '0; sig_pwr = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_mse", mse_out, 0);
      chk("rst_ratio", mer_ratio, 0);
      chk("rst_busy", busy, 0);

      win(4, 4, 4, 4, 256);
      chk("t1_mse", mse_out, 16);
      chk("t1_dc", dc_out, 4);
      chk("t1_ratio", mer_ratio, 'h1000);
      chk("t1_pulses", npulse - p0, 1);

      win(3, -3, 3, -3, 9);
      chk("t2_mse", mse_out, 9);
      chk("t2_dc", dc_out, 0);
      chk("t2_ratio", mer_ratio, 'h0100);

      win(-5, -5, -5, -5, 1000);
      chk("t3_dc_raw", $unsigned(dc_out), 'h3FFFB);
      chk("t3_mse", mse_out, 25);
      chk("t3_ratio", mer_ratio, 10240);

      win(-1, -1, -1, 0, 100);
      chk("t4_dc_floor", dc_out, -1);
      chk("t4_ratio", mer_ratio, 'hFFFF);

      win(0, 0, 0, 0, 100);
      chk("t5_mse", mse_out, 0);
      chk("t5_ratio", mer_ratio, 'hFFFF);

      win(1, 1, 1, 1, 64'd1 << 30);
      chk("t6_mse", mse_out, 1);
      chk("t6_ratio", mer_ratio, 'hFFFF);

      win(3, 3, 3, 3, 1000);
      chk("t7_ratio", mer_ratio, 28444);

      win(1, 2, 3, 4, 500);
      chk("t8_mse", mse_out, 7);
      chk("t8_dc", dc_out, 2);
      chk("t8_ratio", mer_ratio, 18285);

      win(-131072, -131072, -131072, -131072, 64'd1 << 35);
      chk("t9_mse", mse_out, 64'd1 << 34);
      chk("t9_dc", dc_out, -131072);
      chk("t9_ratio", mer_ratio, 512);

      chk("pre_ovr", overrun, 0);
      p0 = npulse;
      clk_en = 1'b1; err = 18'sd2; sig_pwr = 36'd64;
      repeat (12) step();
      clk_en = 1'b0;
      repeat (30) step();
      chk("ovr_flag", overrun, 1);
      chk("ovr_pulses", npulse - p0, 1);
      chk("ovr_mse", mse_out, 4);
      chk("ovr_ratio", mer_ratio, 'h1000);

      win(5, 5, 5, 5, 25);
      chk("ovr_sticky", overrun, 1);
      chk("t10_ratio", mer_ratio, 'h0100);

      p0 = npulse;
      send_sym(7, 490);
      send_sym(7, 490);
      send_sym(7, 490);
      clk_en = 1'b1; err = 18'sd7;
      step();
      clk_en = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (30) step();
      chk("rmid_pulses", npulse - p0, 0);
      chk("rmid_mse", mse_out, 0);
      chk("rmid_dc", dc_out, 0);
      chk("rmid_ratio", mer_ratio, 0);
      chk("rmid_ovr", overrun, 0);

      win(2, -2, 2, 2, 64);
      chk("post_mse", mse_out, 4);
      chk("post_dc", dc_out, 1);
      chk("post_ratio", mer_ratio, 'h1000);
      chk("post_pulses", npulse - p0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
